// File: rtl/film_fx_pkg.sv
// Shared types and constants for the old-film effect sequencer and its noise source.
package film_fx_pkg;

    typedef enum logic [2:0] {
        ST_MANUAL = 3'd0,
        ST_GRAY   = 3'd1,
        ST_SEPIA  = 3'd2,
        ST_VIG    = 3'd3,
        ST_FILM   = 3'd4
    } fx_state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Enable encodings ordered {grayscale, sepia, vignette}
    localparam logic [2:0] EN_GRAY  = 3'b100;
    localparam logic [2:0] EN_SEPIA = 3'b010;
    localparam logic [2:0] EN_VIG   = 3'b001;
    localparam logic [2:0] EN_FILM  = 3'b011;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [2:0] state_enables(input fx_state_t s);
        case (s)
            ST_GRAY:  return EN_GRAY;
            ST_SEPIA: return EN_SEPIA;
            ST_VIG:   return EN_VIG;
            ST_FILM:  return EN_FILM;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic fx_state_t next_auto(input fx_state_t s);
        case (s)
            ST_GRAY:  return ST_SEPIA;
            ST_SEPIA: return ST_VIG;
            ST_VIG:   return ST_FILM;
            default:  return ST_GRAY;
        endcase
    endfunction

endpackage

// File: rtl/film_lfsr16.sv
// 16-bit Galois LFSR that advances one step whenever step is high.
module film_lfsr16
    import film_fx_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/film_fx_sequencer.sv
// Per-frame controller: VS edge detect, frame noise parameters and effect-enable sequencing.
//   state     | meaning
//   ST_MANUAL | enables follow the board switches
//   ST_GRAY   | auto: grayscale only
//   ST_SEPIA  | auto: sepia only
//   ST_VIG    | auto: vignette only
//   ST_FILM   | auto: sepia + vignette, scratch and blob allowed
module film_fx_sequencer
    import film_fx_pkg::*;
#(
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          DWELL_FRAMES  = 60,
    parameter logic [4:0]  BLOB_THRESH   = 5'd12,
    parameter int          FLICKER_SHIFT = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       VGA_VS,
    input  logic       auto_en,
    input  logic       fx_hold,
    input  logic       grayscale_SW,
    input  logic       sepia_SW,
    input  logic       vignette_SW,
    output logic       frame_start,
    output logic       grayscale_en,
    output logic       sepia_en,
    output logic       vignette_en,
    output logic [9:0] scratch_col,
    output logic       scratch_valid,
    output logic [8:0] blob_row,
    output logic [9:0] blob_col,
    output logic [3:0] blob_r2,
    output logic       blob_valid,
    output logic [7:0] flicker_weight,
    output logic       param_valid
);

    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL_FRAMES - 1);

    logic        vs_q;
    logic        vs_armed;
    logic        fe;
    logic        step;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_n;
    logic [9:0]  col_n;
    logic [8:0]  row_n;
    logic [9:0]  bcol_n;
    logic        scr_ok;
    logic        blob_ok;
    fx_state_t   st;
    fx_state_t   st_nx;
    logic [7:0]  dwell;
    logic [7:0]  dwell_nx;

    // vs_armed blocks a spurious edge when reset is released while VS is already low.
    assign fe   = vs_armed & vs_q & ~VGA_VS;
    assign step = fe & ~fx_hold;

    film_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (step),
        .seed    (SEED_EFF),
        .q       (lfsr_q)
    );

    assign lfsr_n  = lfsr_next(lfsr_q);
    assign col_n   = lfsr_n[9:0];
    assign row_n   = lfsr_n[15:7];
    assign bcol_n  = {lfsr_n[5:0], lfsr_n[15:12]};
    assign scr_ok  = 32'(col_n) < H_ACTIVE;
    assign blob_ok = (32'(row_n) < V_ACTIVE) && (32'(bcol_n) < H_ACTIVE)
                     && (lfsr_n[10:6] > BLOB_THRESH);

    always_comb begin
        st_nx    = ST_MANUAL;
        dwell_nx = 8'd0;
        if (auto_en) begin
            if (st == ST_MANUAL) begin
                st_nx = ST_GRAY;
            end else if (dwell == DWELL_LAST) begin
                st_nx = next_auto(st);
            end else begin
                st_nx    = st;
                dwell_nx = dwell + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q           <= 1'b1;
            vs_armed       <= 1'b0;
            frame_start    <= 1'b0;
            st             <= ST_MANUAL;
            dwell          <= 8'd0;
            grayscale_en   <= 1'b0;
            sepia_en       <= 1'b0;
            vignette_en    <= 1'b0;
            scratch_col    <= 10'd0;
            scratch_valid  <= 1'b0;
            blob_row       <= 9'd0;
            blob_col       <= 10'd0;
            blob_r2        <= 4'd0;
            blob_valid     <= 1'b0;
            flicker_weight <= 8'd255;
            param_valid    <= 1'b0;
        end else begin
            vs_q        <= VGA_VS;
            vs_armed    <= vs_armed | VGA_VS;
            frame_start <= fe;
            if (step) begin
                st             <= st_nx;
                dwell          <= dwell_nx;
                param_valid    <= 1'b1;
                scratch_col    <= col_n;
                blob_row       <= row_n;
                blob_col       <= bcol_n;
                blob_r2        <= lfsr_n[3:0];
                flicker_weight <= 8'd255 - (lfsr_n[7:0] >> FLICKER_SHIFT);
                if (st_nx == ST_MANUAL) begin
                    {grayscale_en, sepia_en, vignette_en} <= {grayscale_SW, sepia_SW, vignette_SW};
                    scratch_valid <= scr_ok;
                    blob_valid    <= blob_ok;
                end else begin
                    {grayscale_en, sepia_en, vignette_en} <= state_enables(st_nx);
                    scratch_valid <= scr_ok && (st_nx == ST_FILM);
                    blob_valid    <= blob_ok && (st_nx == ST_FILM);
                end
            end
        end
    end

endmodule
